fetch_prefetch_buffer: RTL
==========================

Name: fetch_prefetch_buffer

Overview:
Instruction fetch stage upstream of the decode/control unit in the 8-bit single-cycle core. It owns the fetch PC and issues word fetches to the instruction memory over a req/rvalid interface, with at most one request outstanding. Returned 16-bit instructions, each tagged with its PC, go into a small in-order FIFO. Decode drains the FIFO over a valid/ready handshake. A branch redirect flushes the FIFO and restarts fetch at a new PC.

Parameters:
PC_W, 8, fetch PC / instruction address width
INSTR_W, 16, instruction width
DEPTH, 4, FIFO entries (power of 2, ≥2)
RESET_PC, 0, fetch PC after reset
PC_INC, 1, PC increment per fetched instruction

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request, valid for one cycle per request
imem_addr  out  PC_W  fetch address; equals fetch_pc
imem_rvalid  in  1  response valid; in order; arrives ≥1 cycle after its req
imem_rdata  in  INSTR_W  response instruction word
redirect  in  1  branch taken; flush and refetch
redirect_pc  in  PC_W  new fetch PC
instr_valid  out  1  FIFO head valid to decode
instr  out  INSTR_W  FIFO head instruction
instr_pc  out  PC_W  PC of FIFO head
instr_ready  in  1  decode accepts head
fifo_count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, active-high): fetch_pc=RESET_PC, count=0, rd/wr ptr=0, state=RUN. imem_req=0, instr_valid=0, fifo_count=0 while reset is high.
- FSM states:
  - RUN: no request outstanding.
  - WAIT: one request outstanding.
  - DROP: one request outstanding whose response must be discarded.
- imem_req is combinational = (state==RUN) && (count<DEPTH) && !redirect.
- The slot is reserved at issue, so a response always fits. There is never a push into a full FIFO.
- On issue: state RUN→WAIT, issued_pc<=fetch_pc, fetch_pc<=fetch_pc+PC_INC (mod 2^PC_W; 8'hFF+1→8'h00).
- WAIT & imem_rvalid & !redirect: push {imem_rdata, issued_pc}; state→RUN. A new request can issue the next cycle, so best-case throughput is 1 instruction per 2 cycles.
- instr_valid = (count!=0) && !redirect. Pop on instr_valid && instr_ready.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- redirect (highest priority):
  - Flush the FIFO (count=0, ptrs=0) and ignore instr_ready.
  - fetch_pc<=redirect_pc. No request issues that cycle.
  - WAIT & !imem_rvalid → DROP.
  - WAIT & imem_rvalid → the response is discarded and state→RUN.
  - DROP stays DROP unless imem_rvalid, in which case it goes to RUN.
  - RUN stays RUN.
- DROP & imem_rvalid (no redirect): discard the data; state→RUN.
- Consecutive redirects: the last redirect_pc wins.
- imem_rvalid while in RUN is a protocol error. It is ignored and the FIFO is unchanged.
- Outputs instr/instr_pc are driven straight from FIFO storage with no extra latency. The first instruction is visible 1 cycle after rvalid.

Optional Feature:
PREFETCH_STATS_EN:
- Defined: adds output drop_count [7:0], which counts every discarded response (redirect-with-rvalid, or rvalid in DROP). It saturates at 255 and is reset to 0 by reset.
- Undefined: the port and its logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset release, memory latency 1, instr_ready=1, mem[0..3]=16'h1111..16'h4444 → requests to 0,1,2,3 on alternate cycles. Decode sees (pc0,1111),(pc1,2222),… in order, and fifo_count stays ≤1.
- instr_ready=0 for 20 cycles → exactly 4 requests (addr 0–3), fifo_count=4, imem_req held 0. Raising ready drains 4 entries in 4 cycles, then fetch resumes at addr 4.
- Memory latency 3 and redirect to 8'h40 while a request to addr 2 is outstanding → FSM in DROP. The late addr-2 response is dropped, the next request is addr 8'h40, and the first decoded instr_pc=8'h40.
- Redirect in the same cycle as imem_rvalid with 2 entries queued → instr_valid=0 that cycle, FIFO empties, response discarded, next cycle imem_req=1 with addr=redirect_pc.
- Redirect to 8'hFE, free-running → fetch addresses 8'hFE, 8'hFF, 8'h00, 8'h01 (wrap).
- Assert reset mid-WAIT with 3 entries queued → imem_req=0, instr_valid=0, fifo_count=0 immediately. After release, fetch restarts at RESET_PC. With PREFETCH_STATS_EN defined, drop_count reads 0.

Source files
------------

// File: rtl/fetch_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_prefetch_buffer
// Purpose  : Instruction fetch stage. Owns the fetch PC, issues one word
//            fetch at a time to instruction memory (req/rvalid), and queues
//            returned instructions with their PCs in a small in-order FIFO
//            that decode drains over a valid/ready handshake. A branch
//            redirect flushes the FIFO and restarts fetch at a new PC.
// Ports    : clk, reset          - clock, asynchronous active-high reset
//            o_imem_req/addr     - fetch request and address (= fetch PC)
//            i_imem_rvalid/rdata - in-order fetch response
//            i_redirect/_pc      - branch redirect and its target PC
//            o_instr_valid/instr/instr_pc, i_instr_ready - decode handshake
//            o_fifo_count        - FIFO occupancy
//            o_drop_count        - discarded responses, saturating
//                                  (only with PREFETCH_STATS_EN)
// Options  : `define PREFETCH_STATS_EN to add the drop_count statistic.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_prefetch_buffer #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] PC_INC   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    o_imem_req,
  output logic [PC_W-1:0]         o_imem_addr,
  input  logic                    i_imem_rvalid,
  input  logic [INSTR_W-1:0]      i_imem_rdata,
  input  logic                    i_redirect,
  input  logic [PC_W-1:0]         i_redirect_pc,
  output logic                    o_instr_valid,
  output logic [INSTR_W-1:0]      o_instr,
  output logic [PC_W-1:0]         o_instr_pc,
  input  logic                    i_instr_ready,
  output logic [$clog2(DEPTH):0]  o_fifo_count
`ifdef PREFETCH_STATS_EN
  ,
  output logic [7:0]              o_drop_count
`endif
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  // RUN: idle, WAIT: response pending, DROP: pending response is stale
  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t               r_state;
  logic [PC_W-1:0]      r_fetch_pc;
  logic [PC_W-1:0]      r_issued_pc;
  logic [c_cnt_w-1:0]   r_count;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [INSTR_W-1:0]   r_fifo_instr [DEPTH];
  logic [PC_W-1:0]      r_fifo_pc    [DEPTH];

  logic w_issue;
  logic w_push;
  logic w_pop;
  logic w_discard;

  // The FIFO slot is reserved when the request issues (count counts only
  // filled entries, but at most one response is in flight and issue needs
  // count<DEPTH), so a push can never overflow.
  assign w_issue   = (r_state == S_RUN) && (r_count < c_depth) && !i_redirect && !reset;
  assign w_push    = (r_state == S_WAIT) && i_imem_rvalid && !i_redirect;
  assign w_pop     = o_instr_valid && i_instr_ready;
  assign w_discard = i_imem_rvalid &&
                     ((r_state == S_DROP) || ((r_state == S_WAIT) && i_redirect));

  assign o_imem_req    = w_issue;
  assign o_imem_addr   = r_fetch_pc;
  assign o_instr_valid = (r_count != '0) && !i_redirect;
  assign o_instr       = r_fifo_instr[r_rd_ptr];
  assign o_instr_pc    = r_fifo_pc[r_rd_ptr];
  assign o_fifo_count  = r_count;

  // FSM, fetch PC and FIFO bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_fetch_pc  <= RESET_PC;
      r_issued_pc <= RESET_PC;
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
    end else if (i_redirect) begin
      r_fetch_pc <= i_redirect_pc;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      case (r_state)
        S_WAIT:  r_state <= i_imem_rvalid ? S_RUN : S_DROP;
        S_DROP:  r_state <= i_imem_rvalid ? S_RUN : S_DROP;
        default: r_state <= S_RUN;
      endcase
    end else begin
      case (r_state)
        S_RUN: begin
          // rvalid here is a protocol error and is simply ignored
          if (w_issue) begin
            r_state     <= S_WAIT;
            r_issued_pc <= r_fetch_pc;
            r_fetch_pc  <= r_fetch_pc + PC_INC;
          end
        end
        S_WAIT:  if (i_imem_rvalid) r_state <= S_RUN;
        S_DROP:  if (i_imem_rvalid) r_state <= S_RUN;
        default: r_state <= S_RUN;
      endcase

      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage needs no reset; occupancy gates visibility
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_instr[r_wr_ptr] <= i_imem_rdata;
      r_fifo_pc[r_wr_ptr]    <= r_issued_pc;
    end
  end

`ifdef PREFETCH_STATS_EN
  logic [7:0] r_drop_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop_count <= '0;
    end else if (w_discard && (r_drop_count != 8'hFF)) begin
      r_drop_count <= r_drop_count + 8'd1;
    end
  end

  assign o_drop_count = r_drop_count;
`else
  logic w_unused_discard;
  assign w_unused_discard = w_discard;
`endif

endmodule
`default_nettype wire
